// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for a STAGES-deep CIC decimator: integrator qualify, comb strobe wave, rate changes.
// Optional macro CIC_FLUSH_EN blanks the first STAGES new-rate outputs after every rate change.
module cic_decim_ctrl #(
  parameter int STAGES       = 3,
  parameter int RATE_WIDTH   = 8,
  parameter int DEFAULT_RATE = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inp_samp_str,
  input  logic [RATE_WIDTH-1:0] rate_val,
  input  logic                  rate_req,
  output logic                  rate_ack,
  output logic                  int_str,
  output logic [STAGES-1:0]     comb_str,
  output logic                  out_samp_str,
  output logic [RATE_WIDTH-1:0] cur_rate,
  output logic                  busy
);

  localparam logic [RATE_WIDTH-1:0] RATE_ONE = RATE_WIDTH'(1);
  localparam logic [RATE_WIDTH-1:0] RATE_RST = RATE_WIDTH'(DEFAULT_RATE);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1
`ifdef CIC_FLUSH_EN
    ,
    ST_FLUSH = 2'd2
`endif
  } state_e;

`ifdef CIC_FLUSH_EN
  localparam state_e ST_APPLY = ST_FLUSH;
`else
  localparam state_e ST_APPLY = ST_RUN;
`endif

  state_e                  state_q, state_d;
  logic [RATE_WIDTH-1:0]   cnt_q, cnt_d;
  logic [RATE_WIDTH-1:0]   rate_q, rate_d;
  logic                    tick_q, int_q, ack_q, out_q;
  logic [STAGES-1:0]       tok_q;
  logic                    tick, apply, suppress;
  logic                    flush_done;

  assign tick  = inp_samp_str && (cnt_q == (rate_q - RATE_ONE));
  assign apply = tick && rate_req;

  always_comb begin
    cnt_d = cnt_q;
    if (tick)
      cnt_d = '0;
    else if (inp_samp_str)
      cnt_d = cnt_q + RATE_ONE;
  end

  always_comb begin
    rate_d = rate_q;
    if (apply)
      rate_d = (rate_val == '0) ? RATE_ONE : rate_val;
  end

`ifdef CIC_FLUSH_EN
  // Each token carries a flag marking whether its output must be blanked.
  logic [3:0]        launch_q, launch_d;
  logic              tick_flag_q;
  logic [STAGES-1:0] flag_q;
  logic              flag_launch;

  assign flag_launch = tick && !apply && (state_q == ST_FLUSH) && (launch_q != 4'd0);
  assign suppress    = flag_q[STAGES-1];
  assign flush_done  = (launch_q == 4'd0) && !tick_flag_q && (flag_q == '0);

  always_comb begin
    launch_d = launch_q;
    if (apply)
      launch_d = 4'(STAGES);
    else if (flag_launch)
      launch_d = launch_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      launch_q    <= 4'd0;
      tick_flag_q <= 1'b0;
      flag_q      <= '0;
    end else begin
      launch_q    <= launch_d;
      tick_flag_q <= flag_launch;
      flag_q[0]   <= tick_flag_q;
      for (int k = 1; k < STAGES; k++)
        flag_q[k] <= flag_q[k-1];
    end
  end
`else
  assign suppress   = 1'b0;
  assign flush_done = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (apply)
          state_d = ST_APPLY;
        else if (rate_req)
          state_d = ST_PEND;
      end
      ST_PEND: begin
        if (apply)
          state_d = ST_APPLY;
        else if (!rate_req)
          state_d = ST_RUN;
      end
`ifdef CIC_FLUSH_EN
      ST_FLUSH: begin
        if (apply)
          state_d = ST_FLUSH;
        else if (flush_done)
          state_d = rate_req ? ST_PEND : ST_RUN;
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    busy         = (state_q != ST_RUN) || rate_req;
    rate_ack     = ack_q;
    int_str      = int_q;
    comb_str     = tok_q;
    out_samp_str = out_q;
    cur_rate     = rate_q;
  end

  // tick_q aligns the wave one cycle behind int_str so comb stage 0 sees the fresh integrator sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      rate_q <= RATE_RST;
      tick_q <= 1'b0;
      int_q  <= 1'b0;
      ack_q  <= 1'b0;
      out_q  <= 1'b0;
      tok_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rate_q   <= rate_d;
      tick_q   <= tick;
      int_q    <= inp_samp_str;
      ack_q    <= apply;
      out_q    <= tok_q[STAGES-1] && !suppress;
      tok_q[0] <= tick_q;
      for (int k = 1; k < STAGES; k++)
        tok_q[k] <= tok_q[k-1];
    end
  end

  logic unused_ok;
  assign unused_ok = flush_done;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: directed and random strobes/requests against an event-scheduling model.
module tb_cic_decim_ctrl;
  localparam int S  = 3;
  localparam int RW = 8;
  localparam int DR = 4;
  localparam int N  = 2048;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          inp_samp_str = 1'b0;
  logic [RW-1:0] rate_val = '0;
  logic          rate_req = 1'b0;
  logic          rate_ack, int_str, out_samp_str, busy;
  logic [S-1:0]  comb_str;
  logic [RW-1:0] cur_rate;

  cic_decim_ctrl #(.STAGES(S), .RATE_WIDTH(RW), .DEFAULT_RATE(DR)) dut (
    .clk(clk), .reset_n(reset_n), .inp_samp_str(inp_samp_str), .rate_val(rate_val),
    .rate_req(rate_req), .rate_ack(rate_ack), .int_str(int_str), .comb_str(comb_str),
    .out_samp_str(out_samp_str), .cur_rate(cur_rate), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected outputs, scheduled by absolute cycle number
  logic         exp_int [N];
  logic         exp_out [N];
  logic         exp_ack [N];
  logic [S-1:0] exp_comb[N];

  int  m_rate, m_cnt, m_sup, m_last_sup;
  bit  m_prev_pend, m_flush_on, m_tick, m_apply;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = cyc; i < N; i++) begin
      exp_int[i] = 1'b0; exp_out[i] = 1'b0; exp_ack[i] = 1'b0; exp_comb[i] = '0;
    end
    m_rate = DR; m_cnt = 0; m_sup = 0; m_last_sup = -1;
    m_prev_pend = 0; m_flush_on = 0; m_tick = 0; m_apply = 0;
  endtask

  task automatic check_outputs();
    bit fl;
    fl = m_flush_on && (m_sup > 0 || cyc <= m_last_sup);
    if (!fl) m_flush_on = 0;
    chk("int_str", 32'(int_str), 32'(exp_int[cyc]));
    chk("comb_str", 32'(comb_str), 32'(exp_comb[cyc]));
    chk("out_samp_str", 32'(out_samp_str), 32'(exp_out[cyc]));
    chk("rate_ack", 32'(rate_ack), 32'(exp_ack[cyc]));
    chk("cur_rate", 32'(cur_rate), 32'(m_rate));
    chk("busy", 32'(busy), 32'(rate_req | m_prev_pend | fl));
  endtask

  // Each decimation tick schedules its strobe wave; the apply tick switches the rate.
  task automatic model_update(input bit inp, input bit req, input int val);
    bit sup;
    m_tick  = inp && (m_cnt == m_rate - 1);
    m_apply = m_tick && req;
    exp_int[cyc+1] = inp;
    if (m_tick) begin
      sup = 0;
`ifdef CIC_FLUSH_EN
      sup = !m_apply && (m_sup > 0);
`endif
      for (int k = 0; k < S; k++) exp_comb[cyc+2+k][k] = 1'b1;
      if (sup) begin
        m_sup--;
        m_last_sup = cyc + 2 + S;
      end else begin
        exp_out[cyc+2+S] = 1'b1;
      end
      m_cnt = 0;
    end else if (inp) begin
      m_cnt++;
    end
    if (m_apply) begin
      exp_ack[cyc+1] = 1'b1;
      m_rate = (val == 0) ? 1 : val;
`ifdef CIC_FLUSH_EN
      m_sup = S;
      m_flush_on = 1;
`endif
    end
    m_prev_pend = req && !m_apply;
  endtask

  task automatic step(input bit inp, input bit req, input int val);
    @(negedge clk);
    reset_n = 1'b1;
    inp_samp_str = inp; rate_req = req; rate_val = RW'(val);
    #1;
    check_outputs();
    model_update(inp, req, val);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n = 1'b0; inp_samp_str = 1'b0; rate_req = 1'b0; rate_val = '0;
      #1;
      model_reset();
      check_outputs();
      cyc++;
    end
  endtask

  // Hold a request until the model applies it, bounded.
  task automatic request(input bit inp, input int val);
    int n;
    n = 0;
    m_apply = 0;
    while (!m_apply && n < 60) begin
      step(inp, 1'b1, val);
      n++;
    end
    chk("ack_timeout", 32'(m_apply), 32'd1);
  endtask

  initial begin
    bit req_on;
    int req_val;
    for (int i = 0; i < N; i++) begin
      exp_int[i] = 1'b0; exp_out[i] = 1'b0; exp_ack[i] = 1'b0; exp_comb[i] = '0;
    end
    do_reset(2);

    // Continuous strobes at the default rate
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++)  step(1'b0, 1'b0, 0);

    // Request rate 2 mid-frame at cnt=1
    step(1'b1, 1'b0, 0);
    chk("cnt_before_req", 32'(m_cnt), 32'd1);
    request(1'b1, 2);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2);

    // Request coincides with a tick, rate 0 maps to 1
    for (int i = 0; i < 8 && m_cnt != m_rate - 1; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    chk("same_cycle_apply", 32'(m_apply), 32'd1);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 0);
    chk("rate_is_one", 32'(cur_rate), 32'd1);

    // Back to rate 4, then sparse strobes
    request(1'b1, 4);
    for (int i = 0; i < 48; i++) step(i % 3 == 0, 1'b0, 0);

    // Reset between a tick and its output
    m_tick = 0;
    for (int i = 0; i < 40 && !m_tick; i++) step(i % 3 == 0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    do_reset(1);
    for (int i = 0; i < 36; i++) step(i % 3 == 0, 1'b0, 0);

    // Request dropped before any tick
    step(1'b0, 1'b1, 7);
    step(1'b0, 1'b1, 7);
    step(1'b0, 1'b0, 7);
    step(1'b0, 1'b0, 7);
    chk("rate_unchanged", 32'(cur_rate), 32'(DR));

    // Random strobes and requests
    req_on = 0; req_val = 0;
    for (int i = 0; i < 250; i++) begin
      if (req_on && (m_apply || $urandom_range(0, 14) == 0)) req_on = 0;
      else if (!req_on && $urandom_range(0, 19) == 0) begin
        req_on = 1;
        req_val = $urandom_range(0, 5);
      end
      step(($urandom & 3) != 0, req_on, req_val);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencing controller for a STAGES-deep CIC decimator built from integrator and comb stage instances. It counts input sample strobes and qualifies every integrator update. Every RATE-th sample it launches a strobe wave down the comb chain and emits the output-valid strobe. It also accepts runtime decimation-rate changes through a req/ack handshake, applies them only on a decimation boundary, and optionally blanks the comb-settling outputs that follow a change.

## Interface
- STAGES, 3: number of comb stages driven; range 1..8.
- RATE_WIDTH, 8: width of the rate value.
- DEFAULT_RATE, 4: decimation rate loaded at reset; range 1..2^RATE_WIDTH-1.

- clk  in  1  sample clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inp_samp_str  in  1  input sample strobe; one sample per high cycle.
- rate_val  in  RATE_WIDTH  requested decimation rate; value 0 is treated as 1.
- rate_req  in  1  rate-change request; held high until rate_ack.
- rate_ack  out  1  single-cycle pulse when rate_val is applied.
- int_str  out  1  integrator enable (all integrators); registered copy of inp_samp_str.
- comb_str  out  STAGES  per-stage comb enable; bit k is stage k.
- out_samp_str  out  1  decimated output valid, one cycle per accepted output.
- cur_rate  out  RATE_WIDTH  rate currently in effect.
- busy  out  1  high while a request is pending or a flush is in progress.

## Operation
- Sample counter cnt runs 0..cur_rate-1 and advances only on inp_samp_str.
- Decimation tick: inp_samp_str high and cnt==cur_rate-1. On a tick, cnt wraps to 0.
- cur_rate==1: every strobe is a tick.
- Comb wave: a tick launches a one-hot token. The token is comb_str[0], then shifts one stage per cycle to comb_str[STAGES-1], then out_samp_str.
- Ticks can be back-to-back when cur_rate==1. The shift register carries multiple tokens, and no token is ever lost.
- States:
  - RUN: normal operation.
  - PEND: rate_req seen, waiting for a tick.
  - FLUSH: outputs blanked; see Configuration.
- Transitions:
  - RUN→PEND on rate_req when there is no tick in the same cycle.
  - RUN or PEND→FLUSH on a tick with rate_req high.
  - FLUSH→RUN after STAGES suppressed outputs.
- Apply on the tick cycle:
  - cur_rate ← max(rate_val,1), sampled that cycle; rate_ack pulses.
  - cnt ← 0.
  - The tick itself still completes under the old rate, and its wave is launched.
- rate_req deasserted before ack: return to RUN (or stay in FLUSH) with no change.
- rate_req high during FLUSH: accepted on the next tick. Flush count restarts at STAGES.
- busy = (state≠RUN) | rate_req.

## Timing
- Reset values:
  - int_str, comb_str, out_samp_str, rate_ack: 0.
  - busy: 0.
  - cur_rate: DEFAULT_RATE.
  - cnt: 0; state: RUN; token shift register: 0.
- No flush after reset: integrator and comb registers are already zero-consistent.
- inp_samp_str at cycle t gives int_str at t+1. Upstream data must be registered once to align with int_str.
- Tick at t:
  - comb_str[0] at t+2, one cycle after int_str, so it sees the updated integrator sum.
  - comb_str[k] at t+2+k.
  - out_samp_str at t+2+STAGES.
- rate_ack is asserted at t+1 for a tick at t. cur_rate is visible from t+1.
- reset_n low mid-wave: all tokens are cleared immediately. A pending request is dropped, with no ack.

## Configuration
- CIC_FLUSH_EN defined:
  - After each rate change, the next STAGES out_samp_str pulses are forced low. These are the outputs produced at the new rate, while comb delays still hold old-rate data.
  - comb_str is never masked.
  - busy stays high through FLUSH.
- CIC_FLUSH_EN undefined:
  - The FLUSH state is not built; after apply, the controller goes directly to RUN.
  - All outputs pass through.
  - busy = (state==PEND) | rate_req.

## Test plan
- Reset, DEFAULT_RATE=4, STAGES=3, strobe every cycle for 12 cycles from t=0 → ticks at t=3,7,11; out_samp_str at t=8,12,16; int_str high t=1..12.
- cur_rate=1 with continuous strobes → comb_str[0] high every cycle from t=2 and out_samp_str every cycle from t=5, with no gaps.
- rate_req with rate_val=2 raised mid-frame at cnt=1 → rate_ack one cycle after the next tick. Subsequent ticks every 2 strobes. With CIC_FLUSH_EN, the first 3 new-rate outputs are suppressed; without it, none are suppressed.
- rate_req and a tick in the same cycle, rate_val=0 → ack the next cycle, cur_rate=1. The old-rate output is still emitted.
- Sparse strobes (every 3rd cycle), rate 4, reset_n pulsed low between a tick and its out_samp_str → no out_samp_str, all outputs 0, cur_rate=4, cnt restarts at 0.
- rate_req dropped before a tick → no rate_ack, cur_rate unchanged, busy returns low.
